acq_source_arbiter: RTL and testbench
=====================================

Name: acq_source_arbiter

Overview:
- Parametrised successor to the acquisition mode switcher.
- Routes a start/stop request from USB to one of NUM_SOURCES test engines (normal ACQ, sweep ACQ, S-curve, ADC, GEM efficiency, etc.), selected by ModeSelect.
- Buffers the selected engine's data stream in an internal FIFO and frames it with header/trailer words toward the external USB FIFO.
- Reports run completion, mode errors and data overflow.

Parameters:
- NUM_SOURCES, 6: number of attached test engines.
- DATA_WIDTH, 16: width of data words; must be >= MODE_WIDTH+8.
- MODE_WIDTH, 3: width of ModeSelect; must satisfy 2^MODE_WIDTH >= NUM_SOURCES.
- FIFO_DEPTH, 16: internal buffer depth in words; power of two.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- ModeSelect  in  MODE_WIDTH  source index; sampled only at run start.
- UsbStartStop  in  1  level request; rising edge starts a run, falling edge aborts it.
- SourceStart  out  NUM_SOURCES  one-hot start level to the engines.
- SourceDone  in  NUM_SOURCES  per-engine done pulses.
- SourceData  in  NUM_SOURCES*DATA_WIDTH  packed engine data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- SourceData_en  in  NUM_SOURCES  per-engine data strobes.
- UsbFifoFull  in  1  external FIFO full (backpressure).
- UsbFifoData  out  DATA_WIDTH  framed output word.
- UsbFifoData_en  out  1  write strobe for UsbFifoData.
- Busy  out  1  high in any state other than IDLE.
- TestDone  out  1  one-cycle pulse at end of run.
- ModeError  out  1  one-cycle pulse when a start is rejected.
- Overflow  out  1  sticky; cleared at the next accepted start.

Behaviour:
- Reset is synchronous, active-high, and priority over everything.
  - Every output goes to 0; the FIFO is flushed; the state returns to IDLE.
  - Applies equally mid-run; no trailer is emitted.
- UsbStartStop is registered once. Edges are detected on the registered copy, so reaction is 1 cycle after the input changes.
- FSM IDLE:
  - On a rising edge with ModeSelect < NUM_SOURCES: latch the mode, clear Overflow and the word count, go to HEADER.
  - On a rising edge with ModeSelect >= NUM_SOURCES: pulse ModeError and stay in IDLE.
- FSM HEADER:
  - When UsbFifoFull=0, write {8'hA5, zero-pad, mode} with the mode in the LSBs.
  - Then assert SourceStart[mode] and go to RUN. While UsbFifoFull=1, hold.
- FSM RUN:
  - SourceData_en[mode] pushes SourceData[mode] into the FIFO.
  - A push into a full FIFO is dropped and sets Overflow.
  - Dropped words are not counted; accepted pushes increment a DATA_WIDTH word count, which wraps.
  - SourceDone[mode] or a falling edge of UsbStartStop deasserts SourceStart in the same cycle the FSM leaves RUN for DRAIN.
  - Data_en and Done in the same cycle: the word is pushed.
  - Strobes and done pulses from unselected sources are ignored.
- FSM DRAIN:
  - Pushes from the selected source are still accepted, since engines may flush after done.
  - Go to TRAILER when the FIFO is empty and no push occurred this cycle.
- FSM TRAILER: when UsbFifoFull=0, write the word count, then go to DONE.
- FSM DONE: pulse TestDone for 1 cycle, then go to IDLE.
- Output path:
  - In RUN and DRAIN, pop the FIFO when it is not empty and UsbFifoFull=0.
  - UsbFifoData and UsbFifoData_en are registered: 1-cycle latency from pop decision to strobe.
  - Header and trailer writes are also registered.
  - At most one UsbFifoData_en per cycle; data-word order is preserved.
- Push and pop in the same cycle on a full FIFO: the push succeeds.

Optional Feature:
- Macro: ACQ_RUN_CYCLE_COUNT_EN.
- When defined:
  - A run-duration counter clears at entry to HEADER and increments every cycle until DONE.
  - It saturates at all-ones and is DATA_WIDTH bits wide.
  - One extra word carrying its value is written after the trailer, under the same UsbFifoFull rule, before DONE.
- When undefined: no counter and no extra word.

Decomposition:
- Shared package acq_pkg holds:
  - the FSM state enum (IDLE, HEADER, RUN, DRAIN, TRAILER, CYCLES, DONE);
  - HEADER_TAG = 8'hA5;
  - the default widths.
- One sub-module: acq_sync_fifo.
  - Parametrised DATA_WIDTH/DEPTH, first-word-fall-through.
  - Ports: push, pop, full, empty, flush.

Test Plan:
- Mode 2, UsbStartStop rises; source 2 sends 5 words 0x0011..0x0015 then Done -> USB sees 0xA502, 0x0011..0x0015, 0x0005; TestDone pulses once; SourceStart=0 after Done.
- ModeSelect=7 with NUM_SOURCES=6, start -> ModeError pulse, Busy stays 0, no USB writes.
- Mode 0, UsbFifoFull held high for 40 cycles while source 0 sends 20 words -> 16 words delivered plus header and trailer 0x0010, Overflow=1; Overflow clears at the next start.
- Mode 1 run, UsbStartStop falls after 3 words -> SourceStart[1] drops within 2 cycles; trailer 0x0003 is written.
- Reset asserted mid-RUN with 4 words buffered -> next cycle all outputs 0, no trailer; a following run starts cleanly with header.
- With ACQ_RUN_CYCLE_COUNT_EN, a run of known length N -> extra final word equals N; without the macro -> no extra word.

Source files
------------

// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the acquisition source arbiter: FSM state encoding,
// header tag and default widths used by acq_source_arbiter and acq_sync_fifo.
// -----------------------------------------------------------------------------
package acq_pkg;

   localparam int DEF_NUM_SOURCES = 6;
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_MODE_WIDTH  = 3;
   localparam int DEF_FIFO_DEPTH  = 16;

   // Upper byte of every header word; the selected mode sits in the LSBs.
   localparam logic [7:0] HEADER_TAG = 8'hA5;

   // CYCLES is only visited when ACQ_RUN_CYCLE_COUNT_EN is defined.
   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      RUN,
      DRAIN,
      TRAILER,
      CYCLES,
      DONE
   } acqState_t;

endpackage

// File: rtl/acq_sync_fifo.sv
// -----------------------------------------------------------------------------
// acq_sync_fifo
// Single-clock first-word-fall-through FIFO. popData always shows the oldest
// entry while empty is low. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is ignored.
//
// Ports:
//   Clk       system clock
//   flush     synchronous clear of both pointers (contents become invalid)
//   push      write request, pushData is stored when accepted
//   pushData  word to store
//   pop       read request, advances past popData when not empty
//   popData   oldest stored word
//   full      DEPTH words stored
//   empty     no words stored
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module acq_sync_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16
) (
   input  logic                  Clk,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] pushData,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] popData,
   output logic                  full,
   output logic                  empty
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit tells full from empty when the addresses match.
   logic [ADDR_WIDTH:0]   wrPtr;
   logic [ADDR_WIDTH:0]   rdPtr;
   logic                  doPush;
   logic                  doPop;

   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]) &&
                    (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);
   assign doPop   = pop & ~empty;
   assign doPush  = push & (~full | doPop);
   assign popData = mem[rdPtr[ADDR_WIDTH-1:0]];

   always_ff @(posedge Clk) begin
      if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + (ADDR_WIDTH+1)'(1);
         if (doPop)  rdPtr <= rdPtr + (ADDR_WIDTH+1)'(1);
      end
   end

   // NOTE: the storage array is deliberately not reset; only the pointers are,
   // so it maps onto plain RAM and empty already masks stale contents.
   always_ff @(posedge Clk) begin
      if (doPush) mem[wrPtr[ADDR_WIDTH-1:0]] <= pushData;
   end

endmodule

// File: rtl/acq_source_arbiter.sv
// -----------------------------------------------------------------------------
// acq_source_arbiter
// Starts one of NUM_SOURCES test engines on a USB start/stop request, buffers
// the selected engine's data and frames it as header / data / trailer words
// toward the external USB FIFO.
//
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   ModeSelect      engine index, sampled when a run is accepted
//   UsbStartStop    level request: rising edge starts, falling edge aborts
//   SourceStart     one-hot start level, high only while running
//   SourceDone      per-engine done pulses
//   SourceData      packed engine data, engine i at [i*DATA_WIDTH +: DATA_WIDTH]
//   SourceData_en   per-engine data strobes
//   UsbFifoFull     backpressure from the external FIFO
//   UsbFifoData     framed output word (registered)
//   UsbFifoData_en  write strobe for UsbFifoData (registered)
//   Busy            high outside IDLE
//   TestDone        one-cycle pulse at end of run
//   ModeError       one-cycle pulse when a start names a missing engine
//   Overflow        sticky data-loss flag, cleared by the next accepted start
//
// Build option: ACQ_RUN_CYCLE_COUNT_EN appends a saturating run-length word
// after the trailer.
// DATA_WIDTH must be >= MODE_WIDTH+8 and 2**MODE_WIDTH >= NUM_SOURCES.
// -----------------------------------------------------------------------------
module acq_source_arbiter
   import acq_pkg::*;
#(
   parameter int NUM_SOURCES = DEF_NUM_SOURCES,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int MODE_WIDTH  = DEF_MODE_WIDTH,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic [MODE_WIDTH-1:0]             ModeSelect,
   input  logic                              UsbStartStop,
   output logic [NUM_SOURCES-1:0]            SourceStart,
   input  logic [NUM_SOURCES-1:0]            SourceDone,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0] SourceData,
   input  logic [NUM_SOURCES-1:0]            SourceData_en,
   input  logic                              UsbFifoFull,
   output logic [DATA_WIDTH-1:0]             UsbFifoData,
   output logic                              UsbFifoData_en,
   output logic                              Busy,
   output logic                              TestDone,
   output logic                              ModeError,
   output logic                              Overflow
);

   // One extra bit so NUM_SOURCES == 2**MODE_WIDTH still fits.
   localparam logic [MODE_WIDTH:0] NUM_SRC = NUM_SOURCES[MODE_WIDTH:0];

   acqState_t               stateQ;
   acqState_t               stateD;
   logic                    startStopQ;
   logic                    startStopPrevQ;
   logic                    startRise;
   logic                    startFall;
   logic                    modeValid;
   logic                    acceptStart;
   logic                    rejectStart;
   logic [MODE_WIDTH-1:0]   modeQ;
   logic [DATA_WIDTH-1:0]   wordCountQ;
   logic                    overflowQ;
   logic                    modeErrorQ;
   logic [DATA_WIDTH-1:0]   usbDataQ;
   logic                    usbEnQ;

   logic                    selEn;
   logic                    selDone;
   logic [DATA_WIDTH-1:0]   selData;
   logic                    capturing;
   logic                    pushReq;
   logic                    pushAccept;
   logic                    pushDrop;
   logic                    popReq;
   logic                    fifoFull;
   logic                    fifoEmpty;
   logic [DATA_WIDTH-1:0]   fifoData;
   logic                    outWrite;
   logic [DATA_WIDTH-1:0]   outWord;
   logic [DATA_WIDTH-1:0]   headerWord;

`ifdef ACQ_RUN_CYCLE_COUNT_EN
   logic [DATA_WIDTH-1:0]   runCyclesQ;
`endif

   // Edges are taken on the registered copy, so the FSM reacts one cycle
   // after UsbStartStop changes.
   assign startRise   = startStopQ & ~startStopPrevQ;
   assign startFall   = ~startStopQ & startStopPrevQ;
   assign modeValid   = ({1'b0, ModeSelect} < NUM_SRC);
   assign acceptStart = (stateQ == IDLE) && startRise && modeValid;
   assign rejectStart = (stateQ == IDLE) && startRise && !modeValid;

   // Only the latched engine is observed; everything else is ignored.
   always_comb begin
      selEn   = 1'b0;
      selDone = 1'b0;
      selData = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (modeQ == i[MODE_WIDTH-1:0]) begin
            selEn   = SourceData_en[i];
            selDone = SourceDone[i];
            selData = SourceData[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign capturing  = (stateQ == RUN) || (stateQ == DRAIN);
   assign pushReq    = capturing & selEn;
   assign popReq     = capturing & ~fifoEmpty & ~UsbFifoFull;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign pushAccept = pushReq & (~fifoFull | popReq);
   assign pushDrop   = pushReq & ~pushAccept;

   acq_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .Clk      (Clk),
      .flush    (Reset),
      .push     (pushAccept),
      .pushData (selData),
      .pop      (popReq),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // Next state and the word to be registered onto the USB port.
   // NOTE: every output of this block is given a default first, so no path
   // leaves a value unassigned and no latch can be inferred.
   always_comb begin
      stateD     = stateQ;
      outWrite   = 1'b0;
      outWord    = '0;
      headerWord = '0;
      headerWord[DATA_WIDTH-1 -: 8]  = HEADER_TAG;
      headerWord[MODE_WIDTH-1:0]     = modeQ;

      case (stateQ)
         IDLE: begin
            if (acceptStart) stateD = HEADER;
         end
         HEADER: begin
            if (!UsbFifoFull) begin
               outWrite = 1'b1;
               outWord  = headerWord;
               stateD   = RUN;
            end
         end
         RUN: begin
            if (popReq) begin
               outWrite = 1'b1;
               outWord  = fifoData;
            end
            if (selDone || startFall) stateD = DRAIN;
         end
         DRAIN: begin
            if (popReq) begin
               outWrite = 1'b1;
               outWord  = fifoData;
            end
            // Engines may still flush after done; leave only once quiet.
            if (fifoEmpty && !pushReq) stateD = TRAILER;
         end
         TRAILER: begin
            if (!UsbFifoFull) begin
               outWrite = 1'b1;
               outWord  = wordCountQ;
`ifdef ACQ_RUN_CYCLE_COUNT_EN
               stateD   = CYCLES;
`else
               stateD   = DONE;
`endif
            end
         end
         CYCLES: begin
`ifdef ACQ_RUN_CYCLE_COUNT_EN
            if (!UsbFifoFull) begin
               outWrite = 1'b1;
               outWord  = runCyclesQ;
               stateD   = DONE;
            end
`else
            stateD = DONE;
`endif
         end
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         stateQ         <= IDLE;
         startStopQ     <= 1'b0;
         startStopPrevQ <= 1'b0;
         modeQ          <= '0;
         wordCountQ     <= '0;
         overflowQ      <= 1'b0;
         modeErrorQ     <= 1'b0;
         usbDataQ       <= '0;
         usbEnQ         <= 1'b0;
      end else begin
         stateQ         <= stateD;
         startStopQ     <= UsbStartStop;
         startStopPrevQ <= startStopQ;
         modeErrorQ     <= rejectStart;
         usbEnQ         <= outWrite;
         if (outWrite) usbDataQ <= outWord;

         if (acceptStart) begin
            modeQ      <= ModeSelect;
            wordCountQ <= '0;
            overflowQ  <= 1'b0;
         end else begin
            if (pushAccept) wordCountQ <= wordCountQ + DATA_WIDTH'(1);
            if (pushDrop)   overflowQ  <= 1'b1;
         end
      end
   end

`ifdef ACQ_RUN_CYCLE_COUNT_EN
   // Counts every cycle from HEADER entry up to DONE, saturating at all-ones.
   always_ff @(posedge Clk) begin
      if (Reset || acceptStart) begin
         runCyclesQ <= '0;
      end else if (stateQ != IDLE && stateQ != DONE && runCyclesQ != '1) begin
         runCyclesQ <= runCyclesQ + DATA_WIDTH'(1);
      end
   end
`endif

   // Start level follows the RUN state, so it drops on the same edge the
   // FSM moves to DRAIN.
   always_comb begin
      SourceStart = '0;
      if (stateQ == RUN) begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            if (modeQ == i[MODE_WIDTH-1:0]) SourceStart[i] = 1'b1;
         end
      end
   end

   assign UsbFifoData    = usbDataQ;
   assign UsbFifoData_en = usbEnQ;
   assign Busy           = (stateQ != IDLE);
   assign TestDone       = (stateQ == DONE);
   assign ModeError      = modeErrorQ;
   assign Overflow       = overflowQ;

endmodule

// File: tb/tb_acq_source_arbiter.sv
// -----------------------------------------------------------------------------
// tb_acq_source_arbiter
// Self-checking bench for acq_source_arbiter. Each run's expected USB stream
// (header, accepted data words, trailer count, optional run-length word) is
// built from the stimulus itself and compared against the captured writes.
// Build option: ACQ_RUN_CYCLE_COUNT_EN (must match the RTL build).
// -----------------------------------------------------------------------------
module tb_acq_source_arbiter;

   localparam int NS = 6;
   localparam int DW = 16;
   localparam int MW = 3;

   logic              Clk;
   logic              Reset;
   logic [MW-1:0]     ModeSelect;
   logic              UsbStartStop;
   logic [NS-1:0]     SourceStart;
   logic [NS-1:0]     SourceDone;
   logic [NS*DW-1:0]  SourceData;
   logic [NS-1:0]     SourceData_en;
   logic              UsbFifoFull;
   logic [DW-1:0]     UsbFifoData;
   logic              UsbFifoData_en;
   logic              Busy;
   logic              TestDone;
   logic              ModeError;
   logic              Overflow;

   acq_source_arbiter #(
      .NUM_SOURCES (NS),
      .DATA_WIDTH  (DW),
      .MODE_WIDTH  (MW),
      .FIFO_DEPTH  (16)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .ModeSelect     (ModeSelect),
      .UsbStartStop   (UsbStartStop),
      .SourceStart    (SourceStart),
      .SourceDone     (SourceDone),
      .SourceData     (SourceData),
      .SourceData_en  (SourceData_en),
      .UsbFifoFull    (UsbFifoFull),
      .UsbFifoData    (UsbFifoData),
      .UsbFifoData_en (UsbFifoData_en),
      .Busy           (Busy),
      .TestDone       (TestDone),
      .ModeError      (ModeError),
      .Overflow       (Overflow)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int          errors = 0;
   int          checks = 0;
   logic [DW-1:0] wrQ[$];
   int          wrCycQ[$];
   logic [DW-1:0] expQ[$];
   int          cyc = 0;
   int          busyRiseCyc = 0;
   int          doneCnt = 0;
   int          errCnt = 0;
   bit          busySeen = 0;
   bit          busyPrev = 0;
   bit          forceFull = 0;
   bit          randFull = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: outputs sampled on the falling edge, away from the active edge.
   always @(negedge Clk) begin
      cyc++;
      if (UsbFifoData_en) begin
         wrQ.push_back(UsbFifoData);
         wrCycQ.push_back(cyc);
      end
      if (TestDone)  doneCnt++;
      if (ModeError) errCnt++;
      if (Busy) busySeen = 1;
      if (Busy && !busyPrev) busyRiseCyc = cyc;
      busyPrev = Busy;
   end

   // Backpressure generator, updated after the driver so it sees fresh flags.
   always begin
      @(posedge Clk);
      #2;
      UsbFifoFull = forceFull || (randFull && ($urandom_range(0, 3) == 0));
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clearSources();
      SourceData_en = '0;
      SourceDone    = '0;
   endtask

   task automatic beginRun();
      wrQ.delete();
      wrCycQ.delete();
      expQ.delete();
      doneCnt  = 0;
      errCnt   = 0;
      busySeen = 0;
   endtask

   // Random activity on every engine except the selected one.
   task automatic noise(input int sel);
      for (int i = 0; i < NS; i++) begin
         SourceData[i*DW +: DW] = DW'($urandom);
         if (i != sel) begin
            SourceData_en[i] = 1'($urandom_range(0, 1));
            SourceDone[i]    = ($urandom_range(0, 7) == 0);
         end
      end
   endtask

   task automatic startRun(input int mode);
      ModeSelect   = MW'(mode);
      UsbStartStop = 1'b1;
      for (int k = 0; k < 60 && !SourceStart[mode]; k++) tick();
      check("start_seen", 32'(SourceStart[mode]), 1);
      check("ovf_clear_at_start", 32'(Overflow), 0);
   endtask

   task automatic sendWords(input int mode, input int n, input bit directed,
                            input bit mayJoinDone, output bit doneGiven);
      int sent = 0;
      logic [DW-1:0] w;
      doneGiven = 0;
      while (sent < n) begin
         if (!directed) noise(mode);
         SourceData_en[mode] = 1'b0;
         SourceDone[mode]    = 1'b0;
         if (directed || $urandom_range(0, 2) != 0) begin
            w = directed ? DW'(16'h0011 + sent) : DW'($urandom);
            SourceData[mode*DW +: DW] = w;
            SourceData_en[mode] = 1'b1;
            expQ.push_back(w);
            sent++;
            if (sent == n && mayJoinDone && !directed && $urandom_range(0, 1) == 1) begin
               SourceDone[mode] = 1'b1;
               doneGiven = 1;
            end
         end
         tick();
      end
      clearSources();
   endtask

   // Run-length word: cycles from HEADER entry to the cycle the word is issued.
   task automatic addCyclesExp();
`ifdef ACQ_RUN_CYCLE_COUNT_EN
      if (wrCycQ.size() > 0) expQ.push_back(DW'(wrCycQ[wrCycQ.size()-1] - 1 - busyRiseCyc));
`endif
   endtask

   task automatic finishRun(input string tag, input bit expOvf);
      clearSources();
      for (int k = 0; k < 400 && doneCnt == 0; k++) tick();
      UsbStartStop = 1'b0;
      randFull     = 0;
      forceFull    = 0;
      repeat (3) tick();
      addCyclesExp();
      check({tag, "_len"}, wrQ.size(), expQ.size());
      for (int i = 0; i < wrQ.size() && i < expQ.size(); i++)
         check($sformatf("%s_w%0d", tag, i), 32'(wrQ[i]), 32'(expQ[i]));
      check({tag, "_testdone_cnt"}, doneCnt, 1);
      check({tag, "_busy_end"}, 32'(Busy), 0);
      check({tag, "_overflow"}, 32'(Overflow), 32'(expOvf));
   endtask

   task automatic runNormal(input string tag, input int mode, input int n,
                            input bit directed, input bit rf);
      bit doneGiven;
      beginRun();
      randFull = rf;
      expQ.push_back({8'hA5, 5'd0, 3'(mode)});
      startRun(mode);
      sendWords(mode, n, directed, 1, doneGiven);
      if (!doneGiven) begin
         SourceDone[mode] = 1'b1;
         tick();
         clearSources();
      end
      check({tag, "_srcstart_off"}, 32'(SourceStart), 0);
      expQ.push_back(DW'(n));
      finishRun(tag, 0);
   endtask

   initial begin
      bit dummy;
      int m;
      Reset         = 1'b1;
      ModeSelect    = '0;
      UsbStartStop  = 1'b0;
      SourceDone    = '0;
      SourceData    = '0;
      SourceData_en = '0;
      UsbFifoFull   = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(Busy), 0);
      check("rst_srcstart", 32'(SourceStart), 0);
      check("rst_usb_en", 32'(UsbFifoData_en), 0);
      check("rst_overflow", 32'(Overflow), 0);
      check("rst_testdone", 32'(TestDone), 0);
      Reset = 1'b0;
      repeat (2) tick();

      // Directed: mode 2, words 0x0011..0x0015.
      runNormal("mode2", 2, 5, 1, 0);

      // Start naming a missing engine.
      beginRun();
      ModeSelect   = MW'(6 + $urandom_range(0, 1));
      UsbStartStop = 1'b1;
      repeat (6) tick();
      check("moderr_pulses", errCnt, 1);
      check("moderr_busy", 32'(busySeen), 0);
      check("moderr_writes", wrQ.size(), 0);
      UsbStartStop = 1'b0;
      repeat (2) tick();

      // Overflow: USB side blocked for 40 cycles while 20 words arrive.
      beginRun();
      expQ.push_back(16'hA500);
      startRun(0);
      forceFull = 1;
      for (int i = 0; i < 20; i++) begin
         SourceData[0 +: DW] = DW'($urandom);
         SourceData_en[0]    = 1'b1;
         if (i < 16) expQ.push_back(SourceData[0 +: DW]);
         tick();
      end
      clearSources();
      repeat (20) tick();
      SourceDone[0] = 1'b1;
      tick();
      clearSources();
      forceFull = 0;
      expQ.push_back(16'h0010);
      finishRun("ovf", 1);

      // Randomized runs (at most 16 words, so nothing is dropped).
      for (int r = 0; r < 10; r++) begin
         m = $urandom_range(0, NS-1);
         runNormal($sformatf("rnd%0d", r), m, $urandom_range(0, 16), 0, 1);
      end

      // Abort: UsbStartStop falls after 3 words.
      beginRun();
      expQ.push_back(16'hA501);
      startRun(1);
      sendWords(1, 3, 0, 0, dummy);
      UsbStartStop = 1'b0;
      tick();
      tick();
      check("abort_srcstart_drop", 32'(SourceStart[1]), 0);
      expQ.push_back(16'h0003);
      finishRun("abort", 0);

      // Reset in RUN with 4 words buffered behind a blocked USB FIFO.
      beginRun();
      m = $urandom_range(0, NS-1);
      startRun(m);
      forceFull = 1;
      for (int i = 0; i < 4; i++) begin
         SourceData[m*DW +: DW] = DW'($urandom);
         SourceData_en[m]       = 1'b1;
         tick();
      end
      clearSources();
      tick();
      Reset        = 1'b1;
      UsbStartStop = 1'b0;
      tick();
      check("midrst_busy", 32'(Busy), 0);
      check("midrst_srcstart", 32'(SourceStart), 0);
      check("midrst_usb_en", 32'(UsbFifoData_en), 0);
      check("midrst_usb_data", 32'(UsbFifoData), 0);
      check("midrst_overflow", 32'(Overflow), 0);
      check("midrst_testdone", 32'(TestDone), 0);
      Reset     = 1'b0;
      forceFull = 0;
      repeat (6) tick();
      check("midrst_header_only", wrQ.size(), 1);
      check("midrst_no_done", doneCnt, 0);
      runNormal("post_rst", $urandom_range(0, NS-1), $urandom_range(1, 16), 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
